// File: rtl/v_issue_ctrl.sv
// v_issue_ctrl: single-issue sequencer between the vector decoder and the
// vector functional units. Accepts one decoded instruction over valid/ready,
// latches the winning unit's opcode, holds that unit's gated-clock enable
// until its done pulse, then emits a one-cycle regfile write strobe.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   instr_valid / instr_ready    decoder handshake (ready only in IDLE)
//   v_alu_op, is_mul, v_lsu_op,
//   v_sldu_op, v_red_op          unit requests (0 = none)
//   is_vconfig, v_reg_wr_en      CSR config instr, regfile write request
//   done_*                       unit completion pulses
//   *_clk_en                     BUFGCE enables, one-hot while executing
//   *_q                          latched opcodes of the accepted instruction
//   reg_wr_en, vconfig_wr_en     one-cycle write strobes
//   busy, timeout_err, illegal_err  status (errors sticky until rst)
module v_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] v_alu_op,
  input  logic       is_mul,
  input  logic [3:0] v_lsu_op,
  input  logic [2:0] v_sldu_op,
  input  logic [2:0] v_red_op,
  input  logic       is_vconfig,
  input  logic       v_reg_wr_en,
  input  logic       done_valu,
  input  logic       done_vmul,
  input  logic       done_vsldu,
  input  logic       done_vred,
  input  logic       done_vload,
  input  logic       done_store,
  output logic       valu_clk_en,
  output logic       vmul_clk_en,
  output logic       vsldu_clk_en,
  output logic       vred_clk_en,
  output logic       vlsu_clk_en,
  output logic [3:0] alu_op_q,
  output logic       mul_q,
  output logic [3:0] lsu_op_q,
  output logic [2:0] sldu_op_q,
  output logic [2:0] red_op_q,
  output logic       reg_wr_en,
  output logic       vconfig_wr_en,
  output logic       busy,
  output logic       timeout_err,
  output logic       illegal_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;
  typedef enum logic [2:0] {U_NONE, U_ALU, U_MUL, U_LOAD, U_STORE, U_SLDU, U_RED} unit_e;

  state_e          state;
  unit_e           unit_q;
  unit_e           sel;
  logic [CW-1:0]   cnt;
  logic            wr_q;
  logic            ready_q;
  logic [4:0]      clk_en_q;   // {vlsu, vred, vsldu, vmul, valu}
  logic            lsu_legal;
  logic            lsu_bad;
  logic [2:0]      n_req;
  logic            multi_req;
  logic            accept;
  logic            done_sel;

  assign lsu_legal = (v_lsu_op != 4'd0) && (v_lsu_op <= 4'd12);
  assign lsu_bad   = (v_lsu_op >= 4'd13);
  // An illegal LSU opcode still counts as a request when detecting conflicts.
  assign n_req     = 3'(v_red_op != 3'd0) + 3'(v_sldu_op != 3'd0) + 3'(v_lsu_op != 4'd0)
                   + 3'(is_mul) + 3'(v_alu_op != 4'd0);
  assign multi_req = (n_req > 3'd1);
  assign accept    = instr_valid & ready_q;

  // Fixed-priority winner: VRED > VSLDU > VLSU > VMUL > VALU. An illegal LSU
  // opcode drops out, letting a lower-priority request win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    sel = U_NONE;
    if (v_red_op != 3'd0)        sel = U_RED;
    else if (v_sldu_op != 3'd0)  sel = U_SLDU;
    else if (lsu_legal)          sel = (v_lsu_op >= 4'd7) ? U_STORE : U_LOAD;
    else if (is_mul)             sel = U_MUL;
    else if (v_alu_op != 4'd0)   sel = U_ALU;
  end

  always_comb begin
    done_sel = 1'b0;
    case (unit_q)
      U_ALU:   done_sel = done_valu;
      U_MUL:   done_sel = done_vmul;
      U_SLDU:  done_sel = done_vsldu;
      U_RED:   done_sel = done_vred;
      U_LOAD:  done_sel = done_vload;
      U_STORE: done_sel = done_store;
      default: done_sel = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state         <= IDLE;
      unit_q        <= U_NONE;
      cnt           <= '0;
      wr_q          <= 1'b0;
      ready_q       <= 1'b0;
      clk_en_q      <= '0;
      alu_op_q      <= '0;
      mul_q         <= 1'b0;
      lsu_op_q      <= '0;
      sldu_op_q     <= '0;
      red_op_q      <= '0;
      reg_wr_en     <= 1'b0;
      vconfig_wr_en <= 1'b0;
      timeout_err   <= 1'b0;
      illegal_err   <= 1'b0;
    end else begin
      reg_wr_en     <= 1'b0;
      vconfig_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            illegal_err <= illegal_err | multi_req | lsu_bad;
            unit_q      <= sel;
            alu_op_q    <= (sel == U_ALU) ? v_alu_op : 4'd0;
            mul_q       <= (sel == U_MUL);
            lsu_op_q    <= (sel == U_LOAD || sel == U_STORE) ? v_lsu_op : 4'd0;
            sldu_op_q   <= (sel == U_SLDU) ? v_sldu_op : 3'd0;
            red_op_q    <= (sel == U_RED) ? v_red_op : 3'd0;
            // Stores never write the vector regfile.
            wr_q        <= v_reg_wr_en & (sel != U_STORE) & (sel != U_NONE);
            cnt         <= '0;
            clk_en_q    <= {sel == U_LOAD || sel == U_STORE, sel == U_RED,
                            sel == U_SLDU, sel == U_MUL, sel == U_ALU};
            if (sel != U_NONE) begin
              state   <= EXEC;
              ready_q <= 1'b0;
            end else begin
              vconfig_wr_en <= is_vconfig;
            end
          end
        end
        EXEC: begin
          cnt <= cnt + CW'(1);
          if (done_sel) begin
            state     <= WB;
            clk_en_q  <= '0;
            reg_wr_en <= wr_q;
          end else if (cnt == LAST_CNT) begin
            // Abort: skip WB, drop the instruction without writing.
            state       <= IDLE;
            ready_q     <= 1'b1;
            clk_en_q    <= '0;
            timeout_err <= 1'b1;
            unit_q      <= U_NONE;
            wr_q        <= 1'b0;
            alu_op_q    <= '0;
            mul_q       <= 1'b0;
            lsu_op_q    <= '0;
            sldu_op_q   <= '0;
            red_op_q    <= '0;
          end
        end
        WB: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_ready  = ready_q;
  assign busy         = (state != IDLE);
  assign valu_clk_en  = clk_en_q[0];
  assign vmul_clk_en  = clk_en_q[1];
  assign vsldu_clk_en = clk_en_q[2];
  assign vred_clk_en  = clk_en_q[3];
  assign vlsu_clk_en  = clk_en_q[4];

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Self-checking bench for v_issue_ctrl: a table of single-instruction
// vectors, directed multi-cycle sequences, and randomized transactions
// checked against a transaction-level reference model.
module tb_v_issue_ctrl;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       instr_valid, instr_ready;
  logic [3:0] v_alu_op, v_lsu_op;
  logic       is_mul, is_vconfig, v_reg_wr_en;
  logic [2:0] v_sldu_op, v_red_op;
  logic       done_valu, done_vmul, done_vsldu, done_vred, done_vload, done_store;
  logic       valu_clk_en, vmul_clk_en, vsldu_clk_en, vred_clk_en, vlsu_clk_en;
  logic [3:0] alu_op_q, lsu_op_q;
  logic       mul_q;
  logic [2:0] sldu_op_q, red_op_q;
  logic       reg_wr_en, vconfig_wr_en, busy, timeout_err, illegal_err;

  v_issue_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .v_alu_op(v_alu_op), .is_mul(is_mul), .v_lsu_op(v_lsu_op),
    .v_sldu_op(v_sldu_op), .v_red_op(v_red_op),
    .is_vconfig(is_vconfig), .v_reg_wr_en(v_reg_wr_en),
    .done_valu(done_valu), .done_vmul(done_vmul), .done_vsldu(done_vsldu),
    .done_vred(done_vred), .done_vload(done_vload), .done_store(done_store),
    .valu_clk_en(valu_clk_en), .vmul_clk_en(vmul_clk_en), .vsldu_clk_en(vsldu_clk_en),
    .vred_clk_en(vred_clk_en), .vlsu_clk_en(vlsu_clk_en),
    .alu_op_q(alu_op_q), .mul_q(mul_q), .lsu_op_q(lsu_op_q),
    .sldu_op_q(sldu_op_q), .red_op_q(red_op_q),
    .reg_wr_en(reg_wr_en), .vconfig_wr_en(vconfig_wr_en), .busy(busy),
    .timeout_err(timeout_err), .illegal_err(illegal_err)
  );

  typedef struct packed {
    logic [3:0] alu;
    logic       mul;
    logic [3:0] lsu;
    logic [2:0] sldu;
    logic [2:0] red;
    logic       vcfg;
    logic       wr;
  } instr_t;

  // Expected effect of one accepted instruction.
  typedef struct {
    int         rank;      // priority position of winner, -1 = nothing executes
    int         clk_idx;   // bit in {vlsu, vred, vsldu, vmul, valu}
    int         done_idx;  // bit in {store, vload, vred, vsldu, vmul, valu}
    logic       illegal;
    logic [3:0] alu;
    logic       mul;
    logic [3:0] lsu;
    logic [2:0] sldu;
    logic [2:0] red;
    logic       wr;
    logic       vcfg;
  } exp_t;

  typedef struct {
    instr_t     ins;
    logic [4:0] clk;
    logic       vcfg;
    logic       ierr;
    logic       wr;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  logic terr_exp = 1'b0;
  logic ierr_exp = 1'b0;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input int alu, input int mul, input int lsu,
                                input int sldu, input int red, input int vcfg, input int wr);
    instr_t i;
    i.alu = 4'(alu); i.mul = 1'(mul); i.lsu = 4'(lsu); i.sldu = 3'(sldu);
    i.red = 3'(red); i.vcfg = 1'(vcfg); i.wr = 1'(wr);
    return i;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    i.alu  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
    i.mul  = ($urandom_range(0, 4) == 0);
    i.lsu  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
    i.sldu = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
    i.red  = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0;
    i.vcfg = ($urandom_range(0, 3) == 0);
    i.wr   = 1'($urandom);
    return i;
  endfunction

  // Priority list VRED, VSLDU, VLSU, VMUL, VALU; the first live request wins.
  function automatic exp_t model(input instr_t i);
    exp_t e;
    bit   req [5];
    int   n;
    bit   store;
    e.rank = -1; e.clk_idx = 0; e.done_idx = 0;
    e.alu = '0; e.mul = 1'b0; e.lsu = '0; e.sldu = '0; e.red = '0;
    store  = (i.lsu >= 4'd7);
    req[0] = (i.red != 0);
    req[1] = (i.sldu != 0);
    req[2] = (i.lsu >= 4'd1) && (i.lsu <= 4'd12);
    req[3] = i.mul;
    req[4] = (i.alu != 0);
    n = int'(i.red != 0) + int'(i.sldu != 0) + int'(i.lsu != 0) + int'(i.mul) + int'(i.alu != 0);
    for (int r = 4; r >= 0; r--) if (req[r]) e.rank = r;
    e.illegal = (n > 1) || (i.lsu >= 4'd13);
    case (e.rank)
      0: begin e.red  = i.red;  e.clk_idx = 3; e.done_idx = 3; end
      1: begin e.sldu = i.sldu; e.clk_idx = 2; e.done_idx = 2; end
      2: begin e.lsu  = i.lsu;  e.clk_idx = 4; e.done_idx = store ? 5 : 4; end
      3: begin e.mul  = 1'b1;   e.clk_idx = 1; e.done_idx = 1; end
      4: begin e.alu  = i.alu;  e.clk_idx = 0; e.done_idx = 0; end
      default: ;
    endcase
    e.wr   = i.wr && !(e.rank == 2 && store);
    e.vcfg = (e.rank < 0) && i.vcfg;
    return e;
  endfunction

  function automatic logic [10:0] obs();
    return {instr_ready, busy, vlsu_clk_en, vred_clk_en, vsldu_clk_en, vmul_clk_en,
            valu_clk_en, reg_wr_en, vconfig_wr_en, timeout_err, illegal_err};
  endfunction

  function automatic logic [10:0] mk_obs(input logic rdy, input logic bsy,
                                         input logic [4:0] ce, input logic rw, input logic vw);
    return {rdy, bsy, ce, rw, vw, terr_exp, ierr_exp};
  endfunction

  function automatic logic [14:0] opc();
    return {alu_op_q, mul_q, lsu_op_q, sldu_op_q, red_op_q};
  endfunction

  task automatic drive(input logic v, input instr_t i, input logic [5:0] d);
    instr_valid = v;
    v_alu_op = i.alu; is_mul = i.mul; v_lsu_op = i.lsu; v_sldu_op = i.sldu;
    v_red_op = i.red; is_vconfig = i.vcfg; v_reg_wr_en = i.wr;
    {done_store, done_vload, done_vred, done_vsldu, done_vmul, done_valu} = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0);
    @(negedge clk);
    terr_exp = 1'b0;
    ierr_exp = 1'b0;
    check("reset_out", {21'd0, obs()}, 32'd0);
    check("reset_opc", {17'd0, opc()}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {21'd0, obs()}, {21'd0, mk_obs(1, 0, 0, 0, 0)});
  endtask

  // Called at the negedge of an IDLE cycle (cycle 0). k = cycle whose done is
  // sampled (k > T means the unit never answers). mode 0: clean, 1: random
  // noise on valid/instr/other dones, 2: all other dones held high.
  // Returns at the negedge of the first IDLE cycle after the instruction.
  task automatic run_unit(input instr_t ins, input int k, input int mode);
    exp_t       e;
    int         last_exec;
    int         stop;
    bit         hit;
    logic [5:0] d;
    e = model(ins);
    d = (mode == 1) ? 6'($urandom) : 6'd0;
    drive(1'b1, ins, d);
    ierr_exp = ierr_exp | e.illegal;
    if (e.rank < 0) begin
      @(negedge clk);
      check("nop_out", {21'd0, obs()}, {21'd0, mk_obs(1, 0, 0, 0, e.vcfg)});
      return;
    end
    hit       = (k <= T);
    last_exec = hit ? k : T;
    stop      = hit ? k + 2 : T + 1;
    for (int c = 1; c <= stop; c++) begin
      @(negedge clk);
      if (c <= last_exec) begin
        check("exec_out", {21'd0, obs()}, {21'd0, mk_obs(0, 1, 5'(1 << e.clk_idx), 0, 0)});
        check("exec_opc", {17'd0, opc()}, {17'd0, e.alu, e.mul, e.lsu, e.sldu, e.red});
      end else if (hit && c == k + 1) begin
        check("wb_out", {21'd0, obs()}, {21'd0, mk_obs(0, 1, 0, e.wr, 0)});
        check("wb_opc", {17'd0, opc()}, {17'd0, e.alu, e.mul, e.lsu, e.sldu, e.red});
      end else begin
        if (!hit) terr_exp = 1'b1;
        check("idle_out", {21'd0, obs()}, {21'd0, mk_obs(1, 0, 0, 0, 0)});
        if (!hit) check("timeout_opc", {17'd0, opc()}, 32'd0);
      end
      if (c < stop) begin
        case (mode)
          1:       d = 6'($urandom);
          2:       d = 6'h3f;
          default: d = 6'h00;
        endcase
        if (c < k)       d[e.done_idx] = 1'b0;
        else if (c == k) d[e.done_idx] = 1'b1;
        if (mode == 1) drive(1'($urandom), rnd_instr(), d);
        else           drive(1'b0, '0, d);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t ins;
    vecs[0]  = '{mk(5, 0, 0, 0, 0, 0, 1), 5'b00001, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{mk(0, 1, 0, 0, 0, 0, 0), 5'b00010, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{mk(0, 0, 3, 0, 0, 0, 1), 5'b10000, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{mk(0, 0, 12, 0, 0, 0, 1), 5'b10000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{mk(0, 0, 13, 0, 0, 0, 1), 5'b00000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{mk(0, 1, 15, 0, 0, 0, 1), 5'b00010, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{mk(0, 0, 2, 4, 0, 0, 1), 5'b00100, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{mk(9, 1, 0, 1, 7, 0, 1), 5'b01000, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{mk(0, 0, 0, 0, 0, 1, 1), 5'b00000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{mk(0, 0, 0, 0, 0, 0, 1), 5'b00000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{mk(1, 0, 0, 0, 0, 1, 1), 5'b00001, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{mk(0, 0, 7, 0, 0, 0, 0), 5'b10000, 1'b0, 1'b0, 1'b0};

    // Table: one accept from a fresh reset, done on every unit in cycle 1.
    foreach (vecs[n]) begin
      do_reset();
      drive(1'b1, vecs[n].ins, '0);
      @(negedge clk);
      check($sformatf("vec%0d_accept", n),
            {25'd0, vlsu_clk_en, vred_clk_en, vsldu_clk_en, vmul_clk_en, valu_clk_en, vconfig_wr_en, illegal_err},
            {25'd0, vecs[n].clk, vecs[n].vcfg, vecs[n].ierr});
      if (vecs[n].clk != 5'd0) begin
        drive(1'b0, '0, 6'h3f);
        @(negedge clk);
        check($sformatf("vec%0d_wb", n), {30'd0, reg_wr_en, busy}, {30'd0, vecs[n].wr, 1'b1});
        drive(1'b0, '0, '0);
        @(negedge clk);
        check($sformatf("vec%0d_idle", n), {30'd0, instr_ready, busy}, 32'd2);
      end
    end

    // Directed multi-cycle sequences.
    do_reset();
    run_unit(mk(1, 0, 0, 0, 0, 0, 1), 3, 0);       // VALU add, done in 3rd EXEC cycle
    run_unit(mk(0, 0, 7, 0, 0, 0, 1), 4, 2);       // store, stray dones ignored
    run_unit(mk(3, 0, 0, 0, 2, 0, 1), 2, 0);       // VRED/VALU conflict
    run_unit(mk(0, 1, 0, 0, 0, 0, 1), T + 1, 0);   // VMUL timeout
    run_unit(mk(0, 0, 4, 0, 0, 0, 1), 1, 0);       // load, done in first EXEC cycle

    // Reset in the second EXEC cycle of a VSLDU op.
    do_reset();
    ins = mk(0, 0, 0, 3, 0, 0, 1);
    drive(1'b1, ins, '0);
    @(negedge clk);
    check("rst_exec1", {21'd0, obs()}, {21'd0, mk_obs(0, 1, 5'b00100, 0, 0)});
    drive(1'b0, '0, '0);
    @(negedge clk);
    check("rst_exec2", {21'd0, obs()}, {21'd0, mk_obs(0, 1, 5'b00100, 0, 0)});
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out", {21'd0, obs()}, 32'd0);
    check("rst_mid_opc", {17'd0, opc()}, 32'd0);
    rst = 1'b0;
    drive(1'b0, '0, 6'b000100);
    @(negedge clk);
    check("rst_late_done1", {21'd0, obs()}, {21'd0, mk_obs(1, 0, 0, 0, 0)});
    @(negedge clk);
    check("rst_late_done2", {21'd0, obs()}, {21'd0, mk_obs(1, 0, 0, 0, 0)});
    drive(1'b0, '0, '0);
    @(negedge clk);
    check("rst_late_done3", {21'd0, obs()}, {21'd0, mk_obs(1, 0, 0, 0, 0)});

    // Back-to-back vconfig, NOP, illegal LSU.
    do_reset();
    run_unit(mk(0, 0, 0, 0, 0, 1, 0), 1, 0);
    run_unit(mk(0, 0, 0, 0, 0, 0, 1), 1, 0);
    run_unit(mk(0, 0, 14, 0, 0, 0, 1), 1, 0);
    drive(1'b0, '0, '0);
    @(negedge clk);
    check("b2b_final", {21'd0, obs()}, {21'd0, mk_obs(1, 0, 0, 0, 0)});

    // Randomized transactions against the model.
    do_reset();
    repeat (300) run_unit(rnd_instr(), int'($urandom_range(1, T + 1)), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
